cam_capture_scaler: RTL and testbench

Parametrised camera capture front-end, successor to the single-mode capture block. It sits between the OV-series sensor pixel bus (pclk/vsync/href/8-bit data) and the frame-buffer RAM write port. It pairs bytes into pixels, converts RGB565 or YUV422 input to a 12- or 16-bit output format, and optionally decimates by 2 in both axes. It produces linear RAM addresses, a per-frame done pulse and line-count status.

---
 rtl/cam_capture_scaler.sv | 171 +++++++++++++++++
 tb/tb_cam_capture_scaler.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_scaler.sv
// rtl/cam_capture_scaler.sv - camera byte-pair capture with RGB565/YUV422 conversion and 2x decimation
module cam_capture_scaler #(
    parameter int H_ACT  = 640,
    parameter int V_ACT  = 480,
    parameter int ADDR_W = 19,
    parameter int OUT_W  = 12,
    parameter int VS_ACT = 1
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              cfg_done,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data_in,
    input  logic              fmt,
    input  logic              decim,
    output logic [OUT_W-1:0]  data_out,
    output logic              we_en,
    output logic [ADDR_W-1:0] out_addr,
    output logic              frame_done,
    output logic [11:0]       frame_lines
);

    localparam int              X_W    = $clog2(H_ACT + 1);
    localparam logic [X_W-1:0]  X_MAX  = X_W'(H_ACT);
    localparam logic [11:0]     Y_MAX  = 12'(V_ACT);
    localparam logic            VS_LVL = 1'(VS_ACT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_vs_hist;
    logic [1:0]        r_fill;
    logic              r_href_d;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic [X_W-1:0]    r_x;
    logic [11:0]       r_y;
    logic [ADDR_W-1:0] r_addr;
    logic              r_fmt;
    logic              r_decim;
    logic [OUT_W-1:0]  r_data_out;
    logic              r_we;
    logic [ADDR_W-1:0] r_out_addr;
    logic              r_frame_done;
    logic [11:0]       r_frame_lines;

    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_byte_ok;
    logic              w_in_win;
    logic              w_keep;
    logic              w_href_fall;
    logic [OUT_W-1:0]  w_pix;

    // History only counts once it holds two samples taken with cfg_done high,
    // so a frame already running when capture is enabled never looks like a start.
    assign w_vs_rise   = (r_fill == 2'd2) && (r_vs_hist[0] == VS_LVL) && (r_vs_hist[1] != VS_LVL);
    assign w_vs_fall   = (r_fill == 2'd2) && (r_vs_hist[0] != VS_LVL) && (r_vs_hist[1] == VS_LVL);
    assign w_byte_ok   = (r_state == S_CAP) && href && (vsync == VS_LVL);
    assign w_in_win    = (r_x < X_MAX) && (r_y < Y_MAX);
    assign w_keep      = !r_decim || (!r_x[0] && !r_y[0]);
    assign w_href_fall = (r_state == S_CAP) && r_href_d && !href;

    generate
        if (OUT_W == 16) begin : g_out16
            assign w_pix = r_fmt ? {r_hi[7:3], r_hi[7:2], r_hi[7:3]} : {r_hi, data_in};
        end else begin : g_out12
            logic w_unused_hi;
            assign w_unused_hi = r_hi[3];
            assign w_pix = r_fmt ? {r_hi[7:4], r_hi[7:4], r_hi[7:4]}
                                 : {r_hi[7:4], r_hi[2:0], data_in[7], data_in[4:1]};
        end
    endgenerate

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_vs_hist     <= 2'b00;
            r_fill        <= 2'd0;
            r_href_d      <= 1'b0;
            r_phase       <= 1'b0;
            r_hi          <= 8'd0;
            r_x           <= '0;
            r_y           <= 12'd0;
            r_addr        <= '0;
            r_fmt         <= 1'b0;
            r_decim       <= 1'b0;
            r_data_out    <= '0;
            r_we          <= 1'b0;
            r_out_addr    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_lines <= 12'd0;
        end else begin
            r_we         <= 1'b0;
            r_frame_done <= 1'b0;
            r_href_d     <= href;

            if (cfg_done) begin
                r_vs_hist <= {r_vs_hist[0], vsync};
                if (r_fill != 2'd2) begin
                    r_fill <= r_fill + 2'd1;
                end
            end else begin
                r_fill <= 2'd0;
            end

            if (!cfg_done) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_WAIT;
                    S_WAIT: begin
                        if (w_vs_rise) begin
                            r_fmt      <= fmt;
                            r_decim    <= decim;
                            r_x        <= '0;
                            r_y        <= 12'd0;
                            r_phase    <= 1'b0;
                            r_addr     <= '0;
                            r_out_addr <= '0;
                            r_state    <= S_CAP;
                        end
                    end
                    S_CAP: begin
                        if (w_byte_ok) begin
                            if (!r_phase) begin
                                r_hi    <= data_in;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (w_in_win) begin
                                    r_x <= r_x + 1'b1;
                                    if (w_keep) begin
                                        r_data_out <= w_pix;
                                        r_we       <= 1'b1;
                                        r_out_addr <= r_addr;
                                        r_addr     <= r_addr + 1'b1;
                                    end
                                end
                            end
                        end
                        // A dangling odd byte is dropped by forcing the phase back to even.
                        if (w_href_fall) begin
                            if ((r_x != '0) && (r_y < Y_MAX)) begin
                                r_y <= r_y + 12'd1;
                            end
                            r_x     <= '0;
                            r_phase <= 1'b0;
                        end
                        if (w_vs_fall) begin
                            r_frame_lines <= r_y;
                            r_frame_done  <= 1'b1;
                            r_state       <= S_WAIT;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out    = r_data_out;
    assign we_en       = r_we;
    assign out_addr    = r_out_addr;
    assign frame_done  = r_frame_done;
    assign frame_lines = r_frame_lines;

endmodule

// File: tb/tb_cam_capture_scaler.sv
// tb/tb_cam_capture_scaler.sv - scoreboard bench for cam_capture_scaler (12- and 16-bit outputs)
module tb_cam_capture_scaler;

    localparam int H = 8;
    localparam int V = 6;
    localparam int AW = 19;

    logic pclk = 1'b0;
    logic rst, cfg_done, vsync, href, fmt, decim;
    logic [7:0] data_in;

    logic [11:0]   d12;
    logic [15:0]   d16;
    logic          we12, we16, fd12, fd16;
    logic [AW-1:0] a12, a16;
    logic [11:0]   fl12, fl16;

    always #5 pclk = ~pclk;

    cam_capture_scaler #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .OUT_W(12), .VS_ACT(1)) dut12 (
        .pclk(pclk), .rst(rst), .cfg_done(cfg_done), .vsync(vsync), .href(href),
        .data_in(data_in), .fmt(fmt), .decim(decim), .data_out(d12), .we_en(we12),
        .out_addr(a12), .frame_done(fd12), .frame_lines(fl12));

    cam_capture_scaler #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW), .OUT_W(16), .VS_ACT(1)) dut16 (
        .pclk(pclk), .rst(rst), .cfg_done(cfg_done), .vsync(vsync), .href(href),
        .data_in(data_in), .fmt(fmt), .decim(decim), .data_out(d16), .we_en(we16),
        .out_addr(a16), .frame_done(fd16), .frame_lines(fl16));

    typedef struct {
        int          addr;
        logic [11:0] e12;
        logic [15:0] e16;
        int          due;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int writes = 0;
    int last_addr = -1;
    int marker_addr = -1;
    int fd12_cnt = 0;
    int fd16_cnt = 0;
    logic [11:0] first12;
    logic [15:0] first16;

    // bench-side model of the capture state
    bit   m_cap = 0;
    bit   m_phase = 0;
    bit   m_fmt = 0;
    bit   m_decim = 0;
    int   m_x = 0;
    int   m_y = 0;
    int   m_addr = 0;
    logic [7:0] m_hi;

    function automatic logic [11:0] exp12(input logic f, input logic [7:0] h, input logic [7:0] l);
        if (f) return {h[7:4], h[7:4], h[7:4]};
        return {h[7:4], h[2:0], l[7], l[4:1]};
    endfunction

    function automatic logic [15:0] exp16(input logic f, input logic [7:0] h, input logic [7:0] l);
        if (f) return {h[7:3], h[7:2], h[7:3]};
        return {h, l};
    endfunction

    always @(posedge pclk) cyc++;

    always @(negedge pclk) begin
        if (fd12 === 1'b1) fd12_cnt++;
        if (fd16 === 1'b1) fd16_cnt++;
        if (we12 === 1'b1 || we16 === 1'b1) begin
            n_checks++;
            if (we12 !== we16) begin
                n_fail++;
                $display("FAIL we_sync we12=%b we16=%b", we12, we16);
            end
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write addr=%0d data12=%h data16=%h", a12, d12, d16);
            end else begin
                m_e = q.pop_front();
                n_checks++;
                if (int'(a12) !== m_e.addr || int'(a16) !== m_e.addr) begin
                    n_fail++;
                    $display("FAIL write_addr got %0d/%0d exp %0d", a12, a16, m_e.addr);
                end
                n_checks++;
                if (d12 !== m_e.e12) begin
                    n_fail++;
                    $display("FAIL data12 addr=%0d got %h exp %h", m_e.addr, d12, m_e.e12);
                end
                n_checks++;
                if (d16 !== m_e.e16) begin
                    n_fail++;
                    $display("FAIL data16 addr=%0d got %h exp %h", m_e.addr, d16, m_e.e16);
                end
                n_checks++;
                if (cyc !== m_e.due) begin
                    n_fail++;
                    $display("FAIL write_latency addr=%0d got cycle %0d exp %0d", m_e.addr, cyc, m_e.due);
                end
            end
            writes++;
            last_addr = int'(a12);
            if (a12 == '0) begin
                first12 = d12;
                first16 = d16;
            end
            if (d16 === 16'hABCD) marker_addr = int'(a16);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        href = 1'b1;
        data_in = b;
        if (m_cap) begin
            if (!m_phase) begin
                m_hi = b;
                m_phase = 1;
            end else begin
                m_phase = 0;
                if (m_x < H && m_y < V) begin
                    if (!m_decim || (m_x % 2 == 0 && m_y % 2 == 0)) begin
                        q.push_back('{m_addr, exp12(m_fmt, m_hi, b), exp16(m_fmt, m_hi, b), cyc + 1});
                        m_addr++;
                    end
                    m_x++;
                end
            end
        end
        @(negedge pclk);
    endtask

    task automatic line_end();
        href = 1'b0;
        if (m_cap) begin
            if (m_x > 0 && m_y < V) m_y++;
            m_x = 0;
            m_phase = 0;
        end
        repeat (3) @(negedge pclk);
    endtask

    task automatic send_line(input int npix, input bit odd, input int mark,
                             input logic [7:0] mh, input logic [7:0] ml);
        for (int p = 0; p < npix; p++) begin
            if (p == mark) begin
                send_byte(mh);
                send_byte(ml);
            end else begin
                send_byte(8'h10 + 8'(p));
                send_byte(8'($urandom));
            end
        end
        if (odd) send_byte(8'hEE);
        line_end();
    endtask

    task automatic start_frame(input bit cap);
        vsync = 1'b1;
        repeat (4) @(negedge pclk);
        m_cap = cap;
        m_x = 0;
        m_y = 0;
        m_phase = 0;
        m_addr = 0;
        m_fmt = fmt;
        m_decim = decim;
    endtask

    task automatic end_frame();
        vsync = 1'b0;
        repeat (4) @(negedge pclk);
        m_cap = 0;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cfg_done = 1'b0; vsync = 1'b0; href = 1'b0;
        data_in = 8'h00; fmt = 1'b0; decim = 1'b0;
        repeat (3) @(negedge pclk);
        n_checks++;
        if (d12 !== 12'h000 || d16 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_data got %h/%h exp 0", d12, d16);
        end
        n_checks++;
        if (we12 !== 1'b0 || we16 !== 1'b0) begin
            n_fail++; $display("FAIL reset_we got %b/%b exp 0", we12, we16);
        end
        n_checks++;
        if (a12 !== '0 || a16 !== '0) begin
            n_fail++; $display("FAIL reset_addr got %0d/%0d exp 0", a12, a16);
        end
        n_checks++;
        if (fd12 !== 1'b0 || fl12 !== 12'd0 || fd16 !== 1'b0 || fl16 !== 12'd0) begin
            n_fail++; $display("FAIL reset_frame got fd=%b lines=%0d exp 0", fd12, fl12);
        end
        rst = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    task automatic test_rgb_full();
        int w0, f0, f1;
        cfg_done = 1'b1; fmt = 1'b0; decim = 1'b0;
        repeat (4) @(negedge pclk);
        w0 = writes; f0 = fd12_cnt; f1 = fd16_cnt;
        start_frame(1);
        send_line(H, 0, 0, 8'hF8, 8'h1F);
        for (int l = 1; l < V + 1; l++) send_line(H, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("rgb_writes", writes - w0, H * V);
        check_int("rgb_last_addr", last_addr, H * V - 1);
        check_int("rgb_first12", int'(first12), 'hF0F);
        check_int("rgb_first16", int'(first16), 'hF81F);
        check_int("rgb_frame_done12", fd12_cnt - f0, 1);
        check_int("rgb_frame_done16", fd16_cnt - f1, 1);
        check_int("rgb_frame_lines_sat", int'(fl12), V);
        check_int("rgb_frame_lines16", int'(fl16), V);
    endtask

    task automatic test_decim();
        int w0;
        decim = 1'b1; fmt = 1'b0;
        w0 = writes; marker_addr = -1;
        start_frame(1);
        for (int l = 0; l < V; l++) send_line(H, 0, (l == 2) ? 2 : -1, 8'hAB, 8'hCD);
        end_frame();
        check_int("decim_writes", writes - w0, (H / 2) * (V / 2));
        check_int("decim_last_addr", last_addr, (H / 2) * (V / 2) - 1);
        check_int("decim_pixel_2_2_addr", marker_addr, (H / 2) + 1);
        check_int("decim_frame_lines", int'(fl12), V);
        decim = 1'b0;
    endtask

    task automatic test_yuv();
        int w0;
        fmt = 1'b1; decim = 1'b0;
        w0 = writes;
        start_frame(1);
        send_line(H, 0, 0, 8'h80, 8'($urandom));
        send_line(H, 0, -1, 8'h00, 8'h00);
        fmt = 1'b0;
        send_line(4, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("yuv_first16", int'(first16), 'h8410);
        check_int("yuv_first12", int'(first12), 'h888);
        check_int("yuv_writes", writes - w0, 2 * H + 4);
        check_int("yuv_frame_lines", int'(fl16), 3);
    endtask

    task automatic test_long_line();
        int w0;
        fmt = 1'b0; decim = 1'b0;
        w0 = writes;
        start_frame(1);
        send_line(H + 2, 1, -1, 8'h00, 8'h00);
        send_line(H, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("long_line_writes", writes - w0, 2 * H);
        check_int("long_line_last_addr", last_addr, 2 * H - 1);
        check_int("long_line_frame_lines", int'(fl12), 2);
    endtask

    task automatic test_cfg_done();
        int w0, f0;
        cfg_done = 1'b0;
        repeat (3) @(negedge pclk);
        vsync = 1'b1;
        repeat (2) @(negedge pclk);
        cfg_done = 1'b1;
        w0 = writes; f0 = fd12_cnt;
        repeat (2) @(negedge pclk);
        send_line(H, 0, -1, 8'h00, 8'h00);
        send_line(H, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("cfg_rise_no_writes", writes - w0, 0);
        check_int("cfg_rise_no_done", fd12_cnt - f0, 0);
        start_frame(1);
        send_line(H, 0, -1, 8'h00, 8'h00);
        check_int("cfg_next_frame_writes", writes - w0, H);
        check_int("cfg_next_frame_last", last_addr, H - 1);
        f0 = fd12_cnt;
        send_byte(8'h12);
        m_cap = 0;
        href = 1'b1; data_in = 8'h34; cfg_done = 1'b0;
        @(negedge pclk);
        n_checks++;
        if (we12 !== 1'b0 || we16 !== 1'b0) begin
            n_fail++; $display("FAIL cfg_fall_we got %b/%b exp 0", we12, we16);
        end
        send_line(3, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("cfg_fall_writes", writes - w0, H);
        check_int("cfg_fall_no_done", fd12_cnt - f0, 0);
        cfg_done = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_reset_mid();
        int w0, f0;
        fmt = 1'b0; decim = 1'b0;
        start_frame(1);
        send_line(H, 0, -1, 8'h00, 8'h00);
        send_byte(8'h55);
        check_int("pre_reset_queue_empty", q.size(), 0);
        rst = 1'b0;
        m_cap = 0;
        #1;
        n_checks++;
        if (d12 !== 12'h000 || d16 !== 16'h0000 || we12 !== 1'b0 || a12 !== '0
            || fd12 !== 1'b0 || fl12 !== 12'd0 || fl16 !== 12'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got d=%h we=%b a=%0d fd=%b lines=%0d exp 0",
                     d12, we12, a12, fd12, fl12);
        end
        @(negedge pclk);
        rst = 1'b1;
        w0 = writes; f0 = fd12_cnt;
        send_line(H, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("post_reset_no_writes", writes - w0, 0);
        check_int("post_reset_no_done", fd12_cnt - f0, 0);
        start_frame(1);
        send_line(H, 0, -1, 8'h00, 8'h00);
        end_frame();
        check_int("post_reset_resume_writes", writes - w0, H);
        check_int("post_reset_resume_last", last_addr, H - 1);
        check_int("post_reset_frame_lines", int'(fl12), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge pclk);
        test_reset();
        test_rgb_full();
        test_decim();
        test_yuv();
        test_long_line();
        test_cfg_done();
        test_reset_mid();
        repeat (3) @(negedge pclk);
        check_int("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
